// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between a CPU port (C) and a loader/debug port (D)
// Ports: clk, reset (sync, active-high)
//   C: c_req/c_we/c_addr/c_wdata in; c_gnt, c_rvalid, c_rdata out
//   D: d_req/d_we/d_addr/d_wdata/d_lock in; d_gnt, d_rvalid, d_rdata out
//   wp_en in, wp_err out (sticky dropped CPU write into the instruction region)
//   memory: Address, Write_data, MemRead, MemWrite out; Mem_data in (combinational read)
module mem_port_arbiter #(
    parameter int MEM_WORD_BITS = 8,
    parameter int INST_WORDS    = 32,
    parameter int MAX_WAIT      = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    output logic        c_gnt,
    output logic        c_rvalid,
    output logic [31:0] c_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic        d_lock,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    input  logic        wp_en,
    output logic        wp_err,
    output logic [31:0] Address,
    output logic [31:0] Write_data,
    output logic        MemRead,
    output logic        MemWrite,
    input  logic [31:0] Mem_data
);
    localparam int WW = $clog2(MAX_WAIT + 1);
    typedef enum logic {PORT_C = 1'b0, PORT_D = 1'b1} port_t;
    port_t         last_winner, iss_port;
    logic [WW-1:0] wait_cnt;
    logic          iss_v, iss_we, lock_active, wp_hit;
    always_comb begin
        lock_active = last_winner == PORT_D && d_lock && d_req;
        // under lock C only wins once its wait budget is spent; otherwise plain round-robin
        c_gnt       = c_req && (!d_req || (lock_active ? wait_cnt == WW'(MAX_WAIT) : last_winner == PORT_D));
        d_gnt       = d_req && !c_gnt;
        // the issued address lives in Address, so protection is judged on the issue stage
        wp_hit      = iss_port == PORT_C && wp_en &&
                      {1'b0, Address[MEM_WORD_BITS+1:2]} < (MEM_WORD_BITS+1)'(INST_WORDS);
        MemRead     = iss_v && !iss_we;
        MemWrite    = iss_v && iss_we && !wp_hit;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            last_winner <= PORT_D;
            iss_port    <= PORT_C;
            iss_v       <= 1'b0;
            iss_we      <= 1'b0;
            wait_cnt    <= '0;
            Address     <= '0;
            Write_data  <= '0;
            c_rvalid    <= 1'b0;
            d_rvalid    <= 1'b0;
            c_rdata     <= '0;
            d_rdata     <= '0;
            wp_err      <= 1'b0;
        end else begin
            iss_v <= c_gnt || d_gnt;
            if (c_gnt || d_gnt) begin
                iss_we      <= c_gnt ? c_we : d_we;
                iss_port    <= c_gnt ? PORT_C : PORT_D;
                last_winner <= c_gnt ? PORT_C : PORT_D;
                Address     <= c_gnt ? c_addr : d_addr;
                Write_data  <= c_gnt ? c_wdata : d_wdata;
            end
            wait_cnt <= (c_gnt || !lock_active) ? '0 :
                        (c_req && wait_cnt != WW'(MAX_WAIT)) ? wait_cnt + WW'(1) : wait_cnt;
            c_rvalid <= MemRead && iss_port == PORT_C;
            d_rvalid <= MemRead && iss_port == PORT_D;
            if (MemRead && iss_port == PORT_C) c_rdata <= Mem_data;
            if (MemRead && iss_port == PORT_D) d_rdata <= Mem_data;
            wp_err <= wp_err || (iss_v && iss_we && wp_hit);
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        c_req, c_we, d_req, d_we, d_lock, wp_en;
    logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
    logic        c_gnt, c_rvalid, d_gnt, d_rvalid, wp_err, MemRead, MemWrite;
    logic [31:0] c_rdata, d_rdata, Address, Write_data, Mem_data;
    int          tests = 0;
    int          fails = 0;
    logic [32:0] sb[$];
    logic [31:0] wmem[256];
    bit          written[256];

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_lock(d_lock),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .wp_en(wp_en), .wp_err(wp_err),
        .Address(Address), .Write_data(Write_data), .MemRead(MemRead), .MemWrite(MemWrite),
        .Mem_data(Mem_data)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return written[a[9:2]] ? wmem[a[9:2]] : (32'hA500_0000 | {24'h0, a[9:2]});
    endfunction

    assign Mem_data = mem_word(Address);

    always @(posedge clk) begin
        if (MemWrite) begin
            wmem[Address[9:2]]    <= Write_data;
            written[Address[9:2]] <= 1'b1;
        end
    end

    // response monitor: every rvalid must match the oldest expected response
    always @(negedge clk) begin
        if (c_rvalid || d_rvalid) begin
            logic [32:0] e;
            logic [32:0] got;
            tests++;
            got = {d_rvalid, d_rvalid ? d_rdata : c_rdata};
            if (c_rvalid && d_rvalid) begin
                fails++;
                $display("FAIL rvalid_both: c_rvalid=1 d_rvalid=1, required at most one");
            end else if (sb.size() == 0) begin
                fails++;
                $display("FAIL rvalid_unexpected: port=%0d data=%h, required no response", got[32], got[31:0]);
            end else begin
                e = sb.pop_front();
                if (got !== e) begin
                    fails++;
                    $display("FAIL response: port=%0d data=%h, required port=%0d data=%h",
                             got[32], got[31:0], e[32], e[31:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        c_req = 0; c_we = 0; d_req = 0; d_we = 0; d_lock = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        step();
        step();
        reset = 0;
        sb.delete();
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            step();
            n++;
        end
        step();
        step();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL %s_drain: %0d responses outstanding, required 0", name, sb.size());
        end
    endtask

    task automatic test_reset();
        wp_en = 0; c_addr = 0; d_addr = 0; c_wdata = 0; d_wdata = 0;
        do_reset();
        @(negedge clk);
        tests++;
        if ({MemRead, MemWrite, c_rvalid, d_rvalid, wp_err} !== 5'b0) begin
            fails++;
            $display("FAIL reset_flags: %b, required 00000", {MemRead, MemWrite, c_rvalid, d_rvalid, wp_err});
        end
        tests++;
        if ({Address, Write_data, c_rdata, d_rdata} !== 128'h0) begin
            fails++;
            $display("FAIL reset_data: Address=%h Write_data=%h c_rdata=%h d_rdata=%h, required 0",
                     Address, Write_data, c_rdata, d_rdata);
        end
    endtask

    task automatic test_single_read();
        step();
        c_req = 1; c_we = 0; c_addr = 32'h10;
        @(negedge clk);
        tests++;
        if ({c_gnt, d_gnt} !== 2'b10) begin
            fails++;
            $display("FAIL single_gnt: c_gnt=%b d_gnt=%b, required 1 0", c_gnt, d_gnt);
        end
        sb.push_back({1'b0, 32'hA500_0004});
        step();
        idle();
        @(negedge clk);
        tests++;
        if ({MemRead, MemWrite} !== 2'b10 || Address !== 32'h10) begin
            fails++;
            $display("FAIL single_issue: MemRead=%b MemWrite=%b Address=%h, required 1 0 00000010",
                     MemRead, MemWrite, Address);
        end
        drain("single");
    endtask

    task automatic test_round_robin();
        do_reset();
        c_req = 1; d_req = 1;
        for (int i = 0; i < 4; i++) begin
            logic exp_d;
            exp_d = i[0];
            c_addr = 32'h100 + 32'(i * 4);
            d_addr = 32'h200 + 32'(i * 4);
            @(negedge clk);
            tests++;
            if ({c_gnt, d_gnt} !== {!exp_d, exp_d}) begin
                fails++;
                $display("FAIL rr_gnt[%0d]: c_gnt=%b d_gnt=%b, required %b %b", i, c_gnt, d_gnt, !exp_d, exp_d);
            end
            sb.push_back({exp_d, mem_word(exp_d ? d_addr : c_addr)});
            step();
        end
        idle();
        @(negedge clk);
        tests++;
        if (MemRead !== 1'b1 || Address !== 32'h20C) begin
            fails++;
            $display("FAIL rr_last_issue: MemRead=%b Address=%h, required 1 0000020c", MemRead, Address);
        end
        drain("rr");
    endtask

    task automatic test_lock();
        logic [10:0] c_wins;
        c_wins = 11'b100_0001_0000;
        do_reset();
        d_req = 1; d_lock = 1; d_addr = 32'h304; c_addr = 32'h300;
        @(negedge clk);
        tests++;
        if (d_gnt !== 1'b1) begin
            fails++;
            $display("FAIL lock_first: d_gnt=%b, required 1", d_gnt);
        end
        sb.push_back({1'b1, mem_word(d_addr)});
        step();
        c_req = 1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            tests++;
            if ({c_gnt, d_gnt} !== {c_wins[i], !c_wins[i]}) begin
                fails++;
                $display("FAIL lock_gnt[%0d]: c_gnt=%b d_gnt=%b, required %b %b",
                         i, c_gnt, d_gnt, c_wins[i], !c_wins[i]);
            end
            sb.push_back({!c_wins[i], mem_word(c_wins[i] ? c_addr : d_addr)});
            step();
        end
        idle();
        drain("lock");
    endtask

    task automatic test_write_protect();
        do_reset();
        wp_en = 1;
        c_req = 1; c_we = 1; c_addr = 32'h40; c_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++;
        if (c_gnt !== 1'b1) begin
            fails++;
            $display("FAIL wp_gnt: c_gnt=%b, required 1", c_gnt);
        end
        step();
        idle();
        @(negedge clk);
        tests++;
        if (MemWrite !== 1'b0 || wp_err !== 1'b0) begin
            fails++;
            $display("FAIL wp_issue: MemWrite=%b wp_err=%b, required 0 0", MemWrite, wp_err);
        end
        step();
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++;
        if (wp_err !== 1'b1 || d_gnt !== 1'b1) begin
            fails++;
            $display("FAIL wp_err_set: wp_err=%b d_gnt=%b, required 1 1", wp_err, d_gnt);
        end
        step();
        idle();
        @(negedge clk);
        tests++;
        if (MemWrite !== 1'b1 || Write_data !== 32'hDEAD_BEEF) begin
            fails++;
            $display("FAIL wp_d_write: MemWrite=%b Write_data=%h, required 1 deadbeef", MemWrite, Write_data);
        end
        step();
        d_req = 1; d_we = 0;
        @(negedge clk);
        sb.push_back({1'b1, 32'hDEAD_BEEF});
        step();
        idle();
        drain("wp_read");
        c_req = 1; c_we = 1; c_addr = 32'h7C; c_wdata = 32'h1111_1111;
        step();
        idle();
        @(negedge clk);
        tests++;
        if (MemWrite !== 1'b0 || wp_err !== 1'b1) begin
            fails++;
            $display("FAIL wp_idx31: MemWrite=%b wp_err=%b, required 0 1", MemWrite, wp_err);
        end
        do_reset();
        c_req = 1; c_we = 1; c_addr = 32'h80; c_wdata = 32'h1234_5678;
        step();
        idle();
        @(negedge clk);
        tests++;
        if (MemWrite !== 1'b1) begin
            fails++;
            $display("FAIL wp_idx32: MemWrite=%b, required 1", MemWrite);
        end
        step();
        @(negedge clk);
        tests++;
        if (wp_err !== 1'b0) begin
            fails++;
            $display("FAIL wp_idx32_err: wp_err=%b, required 0", wp_err);
        end
        wp_en = 0;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        c_req = 1; c_we = 0; c_addr = 32'h24;
        @(negedge clk);
        tests++;
        if (c_gnt !== 1'b1) begin
            fails++;
            $display("FAIL midrst_gnt: c_gnt=%b, required 1", c_gnt);
        end
        step();
        idle();
        reset = 1;
        step();
        reset = 0;
        @(negedge clk);
        tests++;
        if ({c_rvalid, d_rvalid, MemRead, MemWrite, wp_err} !== 5'b0 ||
            {Address, Write_data, c_rdata, d_rdata} !== 128'h0) begin
            fails++;
            $display("FAIL midrst_outputs: rv=%b%b rd=%b wr=%b err=%b Address=%h c_rdata=%h, required all 0",
                     c_rvalid, d_rvalid, MemRead, MemWrite, wp_err, Address, c_rdata);
        end
        step();
        c_req = 1; d_req = 1; c_addr = 32'h28; d_addr = 32'h2C;
        @(negedge clk);
        tests++;
        if ({c_gnt, d_gnt} !== 2'b10) begin
            fails++;
            $display("FAIL midrst_tie: c_gnt=%b d_gnt=%b, required 1 0", c_gnt, d_gnt);
        end
        sb.push_back({1'b0, mem_word(c_addr)});
        step();
        idle();
        drain("midrst");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_lock();
        test_write_protect();
        test_reset_mid_op();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Two-requester arbiter for the unified instruction/data memory. It shares the single memory port between the CPU port (C) and a program-loader/debug port (D). Accepted requests are registered and issued to the memory one cycle later, and read data is returned registered. It adds round-robin arbitration, a bounded-starvation bus lock for loader bursts, and write protection of the instruction region against CPU stores.

Parameters:
MEM_WORD_BITS, 8, word-index width; index = addr[MEM_WORD_BITS+1:2]
INST_WORDS, 32, word indices 0..INST_WORDS-1 form the protected instruction region
MAX_WAIT, 4, maximum consecutive cycles C may be denied while D holds the lock

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
c_req  in  1  CPU request valid
c_we  in  1  CPU request is a write
c_addr  in  32  CPU byte address
c_wdata  in  32  CPU write data
c_gnt  out  1  CPU request accepted this cycle (combinational)
c_rvalid  out  1  CPU read data valid (one-cycle pulse)
c_rdata  out  32  CPU read data (registered)
d_req  in  1  loader request valid
d_we  in  1  loader request is a write
d_addr  in  32  loader byte address
d_wdata  in  32  loader write data
d_lock  in  1  loader requests to keep priority
d_gnt  out  1  loader request accepted this cycle (combinational)
d_rvalid  out  1  loader read data valid (one-cycle pulse)
d_rdata  out  32  loader read data (registered)
wp_en  in  1  enable instruction-region write protection
wp_err  out  1  sticky flag: a CPU write into the protected region was dropped
Address  out  32  to memory
Write_data  out  32  to memory
MemRead  out  1  to memory
MemWrite  out  1  to memory
Mem_data  in  32  from memory (combinational read)

Behaviour:
- Clocking and reset: one clock `clk`; reset is synchronous and active-high, on port `reset`.
- Reset values:
  - Outputs: MemRead, MemWrite, c_rvalid, d_rvalid, wp_err = 0; Address, Write_data, c_rdata, d_rdata = 0.
  - Internal: last_winner = D (so C wins the first tie); wait_cnt = 0; issue stage empty.
- Reset mid-operation: any in-flight issue is discarded. No MemWrite and no rvalid may be asserted in the cycle after reset is sampled.
- Arbitration (combinational, cycle N):
  - Exactly one of c_gnt / d_gnt may be high, and only when the matching req is high.
  - Only one requester: it wins.
  - Both request, no lock in effect: the port that is not last_winner wins.
  - Lock in effect (last_winner = D, d_lock = 1, d_req = 1) and wait_cnt < MAX_WAIT: D wins.
  - Lock in effect and wait_cnt = MAX_WAIT: C wins.
- wait_cnt:
  - Increments when C is requesting and denied while the lock is in effect.
  - Clears whenever C is granted, or when the lock is not in effect.
  - Saturates at MAX_WAIT.
- last_winner updates at the posedge on each grant.
- Issue (cycle N+1): at the posedge ending N, the winner's addr/we/wdata and a port tag are registered.
  - During N+1: Address = registered addr; Write_data = registered wdata; MemRead = ~we; MemWrite = we.
  - With no grant in N, MemRead = MemWrite = 0 in N+1.
  - Address/Write_data hold their last value when idle.
- Write protection: a write is suppressed when issued by C, wp_en = 1, and addr[MEM_WORD_BITS+1:2] < INST_WORDS.
  - MemWrite stays 0 for that issue.
  - wp_err is set at the end of N+1 and stays set until reset.
  - The request is still granted (no retry).
  - D writes are never suppressed.
- Read return:
  - At the end of N+1, Mem_data is captured into the tagged port's rdata.
  - That port's rvalid is high for exactly cycle N+2.
  - rdata holds until that port's next read returns.
  - Writes produce no rvalid.
- Throughput: one accepted request per cycle, fully pipelined. A read issued in N+1 and a request granted in N+1 proceed independently.
- Ordering: responses return in grant order. There is no reordering.

Test Plan:
- Single CPU read: after reset, c_req=1, c_we=0, c_addr=0x0000_0010 for one cycle.
  -> c_gnt=1 in cycle 0.
  -> MemRead=1, Address=0x10 in cycle 1.
  -> c_rvalid=1 with c_rdata = memory word 4 in cycle 2.
  -> d_rvalid stays 0 throughout.
- Round-robin: c_req and d_req held high (no lock) for 4 cycles.
  -> grant sequence C, D, C, D.
  -> four issues in cycles 1-4, rvalids alternate C, D in cycles 2-5.
- Lock starvation bound: D holds d_req=d_lock=1 and C holds c_req=1 starting just after a D grant, with MAX_WAIT=4.
  -> D is granted 4 consecutive cycles, then C is granted once, then D again.
  -> wait_cnt returns to 0 after the C grant.
- Write protection: wp_en=1, C writes 0xDEADBEEF to 0x0000_0040 (index 16).
  -> c_gnt=1, MemWrite=0 in the issue cycle, wp_err=1 from the next cycle and sticky.
  -> the same write from D: MemWrite=1, and a later read returns 0xDEADBEEF.
  -> C write to 0x0000_0080 (index 32): MemWrite=1, and wp_err does not newly assert.
- Reset mid-operation: C read granted in cycle N, reset asserted in cycle N+1.
  -> no c_rvalid in N+2; all outputs 0 the cycle after reset is sampled.
  -> first post-reset tie goes to C.
